maxnet_array: RTL and testbench
===============================

# maxnet_array

Parametrised Maxnet winner-take-all engine, the next-generation replacement for the fixed four-input neural network top. It accepts N signed fixed-point activations in one cycle and iterates the lateral-inhibition update a_i ← ReLU(a_i − EPS·Σ_{j≠i} a_j) on all channels in parallel, one iteration per clock, until one channel survives, all channels die, or an iteration limit is hit. It reports the winning channel's original input value and index, plus a tie flag, and sits between the feature-extraction stage and the classifier result register.

## Interface
- N, 4, channel count (≥2)
- W, 32, activation width, signed two's complement
- FRAC, 16, fractional bits of activations and EPS
- EPS, 13107, inhibition weight in Q(W−FRAC).FRAC (0.2); must be < 1/(N−1)
- MAX_ITER, 63, maximum update iterations per run
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-low reset
- start  input  1  run request, sampled only in IDLE
- in_data  input  N*W  channel i at bits [i*W +: W]
- max  output  W  original input value of the winner
- max_idx  output  $clog2(N)  winner channel index
- tie  output  1  no unique winner found
- busy  output  1  high outside IDLE
- Done  output  1  one-cycle completion pulse

## Operation
- States: IDLE → ITER → DONE → IDLE.
- IDLE: on start=1, latch in_data into orig[] and ReLU(in_data) into act[]; clear iteration counter; go ITER.
- ITER, evaluated on registered act[], in priority order:
  - exactly one act[i] > 0: winner i, tie=0 → DONE.
  - all act[] == 0: max=0, max_idx=0, tie=1 → DONE.
  - counter == MAX_ITER: winner = lowest index with act>0, tie=1 → DONE.
  - otherwise: update all act[], increment counter, stay in ITER.
- Update arithmetic: S = Σ act[j] in W+$clog2(N) bits; inh_i = (EPS·(S − act[i])) >>> FRAC, full-precision product then floor; act[i]' = 0 if act[i] − inh_i ≤ 0, else act[i] − inh_i. There is no overflow, because activations only decrease.
- DONE: max, max_idx, and tie are registered on the ITER→DONE transition. Done=1 for exactly one cycle, then the block returns to IDLE.
- max, max_idx, and tie hold until the next ITER→DONE transition.
- start outside IDLE is ignored. in_data is don't-care except in the start cycle.
- Reset (rst=0 at a clock edge), including mid-run: state=IDLE; act[], orig[], and counter are cleared. Outputs after reset: max=0, max_idx=0, tie=0, busy=0, Done=0.

## Timing
- start is sampled at edge t. busy=1 from t+1. Each ITER cycle performs either one update or the exit decision.
- With k updates, Done=1 in cycle t+2+k, and busy=1 through that cycle.
- Minimum latency is 2 cycles (k=0). Maximum is MAX_ITER+2.
- A start that is high in the DONE cycle is ignored. A start in the following IDLE cycle is accepted, so runs can be issued back-to-back with one IDLE cycle between them.

## Configuration
- MAXNET_ITER_CNT_EN defined:
  - Adds output port iter_cnt, width $clog2(MAX_ITER+1).
  - iter_cnt is the number of updates k, registered alongside max on the ITER→DONE transition.
  - Reset value is 0.
- Not defined: the port is absent. The internal counter and all other behaviour are identical.

## Structure
- Package maxnet_pkg:
  - state enum {IDLE, ITER, DONE}
  - default EPS/FRAC constants
  - sum-width helper localparam function
- Sub-module maxnet_cell, instantiated N times:
  - holds act[i]
  - inputs: S, load strobe, load value, update enable
  - computes inh_i and the ReLU
  - outputs act[i] and nonzero flag
- Top level contains the FSM, the adder tree for S, nonzero count and priority encoder, orig[] registers, and the output registers.

## Test plan
- N=4, Q16 inputs {0x10000, 0x20000, 0x30000, 0x40000}, start at t → Done at t+7 (5 updates), max=0x40000, max_idx=3, tie=0.
- Inputs {−0x10000, 0x18000, −1, 0} → Done at t+2, max=0x18000, max_idx=1, tie=0.
- All inputs 0 → Done at t+2, max=0, max_idx=0, tie=1.
- All inputs 0x10000 → activations stall at 1 LSB; Done at t+65, tie=1, max=0x10000, max_idx=0. With MAXNET_ITER_CNT_EN defined, iter_cnt=63.
- Start the first vector, pulse start again at t+3, then drive rst=0 at t+4 → second start ignored. After reset: IDLE, busy=0, max=0, Done never asserted. A new start runs normally.
- Back-to-back runs: first vector, then {5, 0, 0, 9} started in the cycle after Done → second Done reports max=9, max_idx=3. Outputs hold the first result until then.

Source files
------------

// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared types and constants for the Maxnet winner-take-all engine.
//   state_e    - control FSM states
//   DEF_*      - default numeric configuration (Q16.16 activations, EPS = 0.2)
//   sum_width  - width needed to sum n activations of width w without overflow
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_W        = 32;
  localparam int unsigned DEF_FRAC     = 16;
  localparam int unsigned DEF_EPS      = 13107;
  localparam int unsigned DEF_MAX_ITER = 63;

  function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/maxnet_if.sv
// maxnet_if: run request / result bundle of the Maxnet engine.
//   start, in_data (N*W, channel i at [i*W +: W])       : requester -> engine
//   max, max_idx, tie, busy, Done, [iter_cnt]            : engine -> requester
// iter_cnt exists only when MAXNET_ITER_CNT_EN is defined.
interface maxnet_if #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned MAX_ITER = 63
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_ITER + 1);

  logic           start;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   max;
  logic [IW-1:0]  max_idx;
  logic           tie;
  logic           busy;
  logic           Done;
`ifdef MAXNET_ITER_CNT_EN
  logic [CW-1:0]  iter_cnt;

  modport master (output start, in_data,
                  input  max, max_idx, tie, busy, Done, iter_cnt);
  modport slave  (input  start, in_data,
                  output max, max_idx, tie, busy, Done, iter_cnt);
`else
  modport master (output start, in_data,
                  input  max, max_idx, tie, busy, Done);
  modport slave  (input  start, in_data,
                  output max, max_idx, tie, busy, Done);
`endif

endinterface

// File: rtl/maxnet_cell.sv
// maxnet_cell: one Maxnet channel. Holds act[i], applies lateral inhibition.
//   clk, rst       : clock, synchronous active-low reset
//   sum            : sum of all channel activations (SW bits, signed)
//   load, load_val : load ReLU(load_val) into the activation
//   upd            : apply act <- ReLU(act - floor(EPS*(sum-act) >> FRAC))
//   act            : current activation (registered)
//   nonzero_c      : act > 0
module maxnet_cell
  import maxnet_pkg::*;
#(
  parameter int unsigned W    = DEF_W,
  parameter int unsigned FRAC = DEF_FRAC,
  parameter int unsigned EPS  = DEF_EPS,
  parameter int unsigned SW   = sum_width(DEF_W, DEF_N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [SW-1:0] sum,
  input  logic                load,
  input  logic signed [W-1:0] load_val,
  input  logic                upd,
  output logic signed [W-1:0] act,
  output logic                nonzero_c
);

  // Product width covers the full-precision EPS * (sum - act)
  localparam int unsigned PW = SW + W;
  localparam logic signed [PW-1:0] EPS_P = PW'(EPS);

  logic signed [W-1:0]  act_q;
  logic signed [SW-1:0] others;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] inh;
  logic signed [PW-1:0] diff;
  logic signed [W-1:0]  upd_val;
  logic signed [W-1:0]  load_relu;

  // Inhibition term (arithmetic shift = floor) and ReLU of the result
  always_comb begin
    others    = sum - SW'(act_q);
    prod      = PW'(others) * EPS_P;
    inh       = prod >>> FRAC;
    diff      = PW'(act_q) - inh;
    upd_val   = (diff <= 0) ? '0 : W'(diff);
    load_relu = load_val[W-1] ? '0 : load_val;
  end

  always_ff @(posedge clk) begin
    if (!rst)      act_q <= '0;
    else if (load) act_q <= load_relu;
    else if (upd)  act_q <= upd_val;
  end

  assign act       = act_q;
  assign nonzero_c = (act_q > 0);

endmodule

// File: rtl/maxnet_array.sv
// maxnet_array: parametrised Maxnet winner-take-all engine.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : maxnet_if slave (start/in_data in; max/max_idx/tie/busy/Done out)
// Optional: MAXNET_ITER_CNT_EN adds bus.iter_cnt = number of updates of the run.
module maxnet_array
  import maxnet_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned FRAC     = DEF_FRAC,
  parameter int unsigned EPS      = DEF_EPS,
  parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
  input  logic     clk,
  input  logic     rst,
  maxnet_if.slave  bus
);

  localparam int unsigned SW   = sum_width(W, N);
  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned CW   = $clog2(MAX_ITER + 1);
  localparam int unsigned NCW  = $clog2(N + 1);

  state_e state, next_state;

  logic signed [W-1:0]  act  [N];
  logic signed [W-1:0]  orig [N];
  logic [N-1:0]         nz;
  logic signed [SW-1:0] sum;
  logic [NCW-1:0]       nz_cnt;
  logic [IW-1:0]        pri_idx;
  logic [CW-1:0]        iter;

  logic                 load, upd, cap;
  logic [W-1:0]         cap_max;
  logic [IW-1:0]        cap_idx;
  logic                 cap_tie;

  logic [W-1:0]         max_q;
  logic [IW-1:0]        max_idx_q;
  logic                 tie_q, busy_q, done_q;

  // Channel cells
  for (genvar i = 0; i < N; i++) begin : g_cell
    maxnet_cell #(.W(W), .FRAC(FRAC), .EPS(EPS), .SW(SW)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .sum       (sum),
      .load      (load),
      .load_val  (bus.in_data[i*W +: W]),
      .upd       (upd),
      .act       (act[i]),
      .nonzero_c (nz[i])
    );
  end

  // Activation sum, survivor count and lowest-index survivor
  always_comb begin
    sum     = '0;
    nz_cnt  = '0;
    pri_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum    = sum + SW'(act[i]);
      nz_cnt = nz_cnt + NCW'(nz[i]);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (nz[i]) pri_idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state and run control; exit checks take priority over an update
  always_comb begin
    next_state = state;
    load       = 1'b0;
    upd        = 1'b0;
    cap        = 1'b0;
    cap_max    = '0;
    cap_idx    = '0;
    cap_tie    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = ITER;
        end
      end
      ITER: begin
        if (nz_cnt == NCW'(1)) begin
          cap        = 1'b1;
          cap_max    = orig[pri_idx];
          cap_idx    = pri_idx;
          next_state = DONE;
        end else if (nz_cnt == '0) begin
          cap        = 1'b1;
          cap_tie    = 1'b1;
          next_state = DONE;
        end else if (iter == CW'(MAX_ITER)) begin
          cap        = 1'b1;
          cap_max    = orig[pri_idx];
          cap_idx    = pri_idx;
          cap_tie    = 1'b1;
          next_state = DONE;
        end else begin
          upd = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Original inputs and update counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N); i++) orig[i] <= '0;
      iter <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < int'(N); i++) orig[i] <= bus.in_data[i*W +: W];
        iter <= '0;
      end else if (upd) begin
        iter <= iter + CW'(1);
      end
    end
  end

  // Result registers hold until the next capture; busy/Done track next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q     <= '0;
      max_idx_q <= '0;
      tie_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (cap) begin
        max_q     <= cap_max;
        max_idx_q <= cap_idx;
        tie_q     <= cap_tie;
      end
      busy_q <= (next_state != IDLE);
      done_q <= (next_state == DONE);
    end
  end

`ifdef MAXNET_ITER_CNT_EN
  logic [CW-1:0] iter_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst)     iter_cnt_q <= '0;
    else if (cap) iter_cnt_q <= iter;
  end

  assign bus.iter_cnt = iter_cnt_q;
`endif

  assign bus.max     = max_q;
  assign bus.max_idx = max_idx_q;
  assign bus.tie     = tie_q;
  assign bus.busy    = busy_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_maxnet_array.sv
// tb_maxnet_array: directed self-checking bench for maxnet_array (N=4, Q16.16).
module tb_maxnet_array;

  localparam int unsigned N        = 4;
  localparam int unsigned W        = 32;
  localparam int unsigned MAX_ITER = 63;

  logic clk;
  logic rst;

  int n_assert;
  int n_fail;

  maxnet_if #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) bus ();

  maxnet_array #(.N(N), .W(W), .FRAC(16), .EPS(13107), .MAX_ITER(MAX_ITER)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one run from a negedge; returns at the negedge of the Done cycle.
  // lat = cycle index of Done counted from the start edge (-1 if never seen).
  task automatic run(input logic [N*W-1:0] d, output int lat, output logic [W-1:0] max_c1);
    bus.in_data = d;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = '0;
    max_c1      = bus.max;
    chk("busy_first_cycle", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      if (bus.Done === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [N*W-1:0] v1, v2, v3, v4, v6;
    logic [W-1:0]   m1;
    int             lat;
    logic           seen;

    n_assert = 0;
    n_fail   = 0;
    v1 = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
    v2 = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_8000, 32'hFFFF_0000};
    v3 = '0;
    v4 = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    v6 = {32'd9, 32'd0, 32'd0, 32'd5};

    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.in_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_max",     64'(bus.max),     64'd0);
    chk("rst_max_idx", 64'(bus.max_idx), 64'd0);
    chk("rst_tie",     64'(bus.tie),     64'd0);
    chk("rst_busy",    64'(bus.busy),    64'd0);
    chk("rst_done",    64'(bus.Done),    64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Ascending inputs: five updates, channel 3 wins
    run(v1, lat, m1);
    chk("v1_latency", 64'(lat),         64'd7);
    chk("v1_max",     64'(bus.max),     64'h0004_0000);
    chk("v1_max_idx", 64'(bus.max_idx), 64'd3);
    chk("v1_tie",     64'(bus.tie),     64'd0);
    chk("v1_busy",    64'(bus.busy),    64'd1);
    @(negedge clk);
    chk("v1_done_pulse", 64'(bus.Done), 64'd0);
    chk("v1_idle_busy",  64'(bus.busy), 64'd0);

    // Negative inputs are clamped; single survivor immediately
    run(v2, lat, m1);
    chk("v2_latency", 64'(lat),         64'd2);
    chk("v2_max",     64'(bus.max),     64'h0001_8000);
    chk("v2_max_idx", 64'(bus.max_idx), 64'd1);
    chk("v2_tie",     64'(bus.tie),     64'd0);
    @(negedge clk);

    // All zero: tie, and a start held in the DONE cycle is ignored
    run(v3, lat, m1);
    chk("v3_latency", 64'(lat),         64'd2);
    chk("v3_max",     64'(bus.max),     64'd0);
    chk("v3_max_idx", 64'(bus.max_idx), 64'd0);
    chk("v3_tie",     64'(bus.tie),     64'd1);
    bus.in_data = v1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = '0;
    chk("done_start_ignored", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("done_start_still_idle", 64'(bus.busy), 64'd0);

    // Equal inputs stall at 1 LSB: iteration limit
    run(v4, lat, m1);
    chk("v4_latency", 64'(lat),         64'd65);
    chk("v4_max",     64'(bus.max),     64'h0001_0000);
    chk("v4_max_idx", 64'(bus.max_idx), 64'd0);
    chk("v4_tie",     64'(bus.tie),     64'd1);
`ifdef MAXNET_ITER_CNT_EN
    chk("v4_iter_cnt", 64'(bus.iter_cnt), 64'd63);
`endif
    @(negedge clk);

    // Mid-run: second start ignored, then reset
    bus.in_data = v1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = '0;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.in_data = v2;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.in_data = '0;
    rst         = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",    64'(bus.busy),    64'd0);
    chk("mid_rst_max",     64'(bus.max),     64'd0);
    chk("mid_rst_max_idx", 64'(bus.max_idx), 64'd0);
    chk("mid_rst_tie",     64'(bus.tie),     64'd0);
    chk("mid_rst_done",    64'(bus.Done),    64'd0);
    rst  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen = seen | bus.Done | bus.busy;
    end
    chk("mid_rst_quiet", 64'(seen), 64'd0);
    run(v2, lat, m1);
    chk("post_rst_latency", 64'(lat),         64'd2);
    chk("post_rst_max",     64'(bus.max),     64'h0001_8000);
    chk("post_rst_max_idx", 64'(bus.max_idx), 64'd1);
    @(negedge clk);

    // Back-to-back runs with one idle cycle between them
    run(v1, lat, m1);
    chk("b2b_first_latency", 64'(lat),     64'd7);
    chk("b2b_first_max",     64'(bus.max), 64'h0004_0000);
    @(negedge clk);
    chk("b2b_idle_busy", 64'(bus.busy), 64'd0);
    chk("b2b_idle_hold", 64'(bus.max),  64'h0004_0000);
    run(v6, lat, m1);
    chk("b2b_hold_during_run", 64'(m1),          64'h0004_0000);
    chk("b2b_second_latency",  64'(lat),         64'd7);
    chk("b2b_second_max",      64'(bus.max),     64'd9);
    chk("b2b_second_max_idx",  64'(bus.max_idx), 64'd3);
    chk("b2b_second_tie",      64'(bus.tie),     64'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
